sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_if.sv | 48 ++++
 rtl/sram_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter_if.sv
// Bus bundle between the two requesting ports, the arbiter and the SRAM
// controller. The arbiter uses the slave view; the environment that drives
// port requests and models the controller uses the master view.
interface sram_arbiter_if;
    logic        p0_wr_en;
    logic        p0_rd_en;
    logic [31:0] p0_addr;
    logic [31:0] p0_wdata;
    logic [31:0] p0_rdata;
    logic        p0_ready;

    logic        p1_wr_en;
    logic        p1_rd_en;
    logic [31:0] p1_addr;
    logic [31:0] p1_wdata;
    logic [31:0] p1_rdata;
    logic        p1_ready;

    logic        mem_wr_en;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    logic [1:0]  grant;
    logic        timeout_err;

    modport slave (
        input  p0_wr_en, p0_rd_en, p0_addr, p0_wdata,
        output p0_rdata, p0_ready,
        input  p1_wr_en, p1_rd_en, p1_addr, p1_wdata,
        output p1_rdata, p1_ready,
        output mem_wr_en, mem_rd_en, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready,
        output grant, timeout_err
    );

    modport master (
        output p0_wr_en, p0_rd_en, p0_addr, p0_wdata,
        input  p0_rdata, p0_ready,
        output p1_wr_en, p1_rd_en, p1_addr, p1_wdata,
        input  p1_rdata, p1_ready,
        input  mem_wr_en, mem_rd_en, mem_addr, mem_wdata,
        output mem_rdata, mem_ready,
        input  grant, timeout_err
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of a single SRAM controller.
// One transaction at a time: IDLE picks a winner and latches its operands,
// ISSUE waits for the controller to go busy (with an abort timeout), WAIT
// holds the request until the controller reports done, DONE releases the
// port for one cycle with the memory enables low.
module sram_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input logic          clk,
    input logic          rst,
    sram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        DONE  = 2'b11
    } state_t;

    // Last ISSUE cycle index before the abort fires.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_r,       state_s;
    logic        mem_wr_en_r,   mem_wr_en_s;
    logic        mem_rd_en_r,   mem_rd_en_s;
    logic [31:0] mem_addr_r,    mem_addr_s;
    logic [31:0] mem_wdata_r,   mem_wdata_s;
    logic [31:0] p0_rdata_r,    p0_rdata_s;
    logic [31:0] p1_rdata_r,    p1_rdata_s;
    logic [1:0]  grant_r,       grant_s;
    logic        last_grant_r,  last_grant_s;   // 1'b0 = port 0, 1'b1 = port 1
    logic [7:0]  tmo_cnt_r,     tmo_cnt_s;
    logic        timeout_err_r, timeout_err_s;

    logic p0_req_s;
    logic p1_req_s;
    logic sel_p1_s;
    logic sel_wr_s;
    logic sel_rd_s;

    assign p0_req_s = bus.p0_wr_en | bus.p0_rd_en;
    assign p1_req_s = bus.p1_wr_en | bus.p1_rd_en;

    // Port 1 wins when it is the only requester, or on a tie when port 0 was served last.
    assign sel_p1_s = p1_req_s & (~p0_req_s | ~last_grant_r);
    assign sel_wr_s = sel_p1_s ? bus.p1_wr_en : bus.p0_wr_en;
    assign sel_rd_s = sel_p1_s ? bus.p1_rd_en : bus.p0_rd_en;

    // Next-state and next-register logic for the transaction FSM.
    always_comb begin
        state_s       = state_r;
        mem_wr_en_s   = mem_wr_en_r;
        mem_rd_en_s   = mem_rd_en_r;
        mem_addr_s    = mem_addr_r;
        mem_wdata_s   = mem_wdata_r;
        p0_rdata_s    = p0_rdata_r;
        p1_rdata_s    = p1_rdata_r;
        grant_s       = grant_r;
        last_grant_s  = last_grant_r;
        tmo_cnt_s     = tmo_cnt_r;
        timeout_err_s = timeout_err_r;

        case (state_r)
            IDLE: begin
                mem_wr_en_s = 1'b0;
                mem_rd_en_s = 1'b0;
                if (p0_req_s | p1_req_s) begin
                    // Write wins over read when a port raises both.
                    mem_wr_en_s = sel_wr_s;
                    mem_rd_en_s = ~sel_wr_s & sel_rd_s;
                    tmo_cnt_s   = 8'd0;
                    state_s     = ISSUE;
                    if (sel_p1_s) begin
                        mem_addr_s  = bus.p1_addr;
                        mem_wdata_s = bus.p1_wdata;
                        grant_s     = 2'b10;
                    end else begin
                        mem_addr_s  = bus.p0_addr;
                        mem_wdata_s = bus.p0_wdata;
                        grant_s     = 2'b01;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (!bus.mem_ready) begin
                    state_s = WAIT;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    // Controller never went busy: abandon without touching rdata.
                    mem_wr_en_s   = 1'b0;
                    mem_rd_en_s   = 1'b0;
                    timeout_err_s = 1'b1;
                    state_s       = DONE;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + 8'd1;
                end
            end
            WAIT: begin
                if (bus.mem_ready) begin
                    mem_wr_en_s = 1'b0;
                    mem_rd_en_s = 1'b0;
                    state_s     = DONE;
                    if (mem_rd_en_r && grant_r[1]) begin
                        p1_rdata_s = bus.mem_rdata;
                    end else if (mem_rd_en_r && grant_r[0]) begin
                        p0_rdata_s = bus.mem_rdata;
                    end else begin
                        p0_rdata_s = p0_rdata_r;
                    end
                end else begin
                    state_s = WAIT;
                end
            end
            DONE: begin
                mem_wr_en_s  = 1'b0;
                mem_rd_en_s  = 1'b0;
                last_grant_s = grant_r[1];
                grant_s      = 2'b00;
                state_s      = IDLE;
            end
            default: begin
                mem_wr_en_s = 1'b0;
                mem_rd_en_s = 1'b0;
                grant_s     = 2'b00;
                state_s     = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by the reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= IDLE;
            mem_wr_en_r   <= 1'b0;
            mem_rd_en_r   <= 1'b0;
            mem_addr_r    <= 32'h0000_0000;
            mem_wdata_r   <= 32'h0000_0000;
            p0_rdata_r    <= 32'h0000_0000;
            p1_rdata_r    <= 32'h0000_0000;
            grant_r       <= 2'b00;
            last_grant_r  <= 1'b1;
            tmo_cnt_r     <= 8'd0;
            timeout_err_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            mem_wr_en_r   <= mem_wr_en_s;
            mem_rd_en_r   <= mem_rd_en_s;
            mem_addr_r    <= mem_addr_s;
            mem_wdata_r   <= mem_wdata_s;
            p0_rdata_r    <= p0_rdata_s;
            p1_rdata_r    <= p1_rdata_s;
            grant_r       <= grant_s;
            last_grant_r  <= last_grant_s;
            tmo_cnt_r     <= tmo_cnt_s;
            timeout_err_r <= timeout_err_s;
        end
    end

    // A port is released in DONE when it owns the bus; otherwise it stalls while requesting.
    assign bus.p0_ready = ((state_r == DONE) & grant_r[0]) | ~p0_req_s;
    assign bus.p1_ready = ((state_r == DONE) & grant_r[1]) | ~p1_req_s;

    assign bus.mem_wr_en   = mem_wr_en_r;
    assign bus.mem_rd_en   = mem_rd_en_r;
    assign bus.mem_addr    = mem_addr_r;
    assign bus.mem_wdata   = mem_wdata_r;
    assign bus.p0_rdata    = p0_rdata_r;
    assign bus.p1_rdata    = p1_rdata_r;
    assign bus.grant       = grant_r;
    assign bus.timeout_err = timeout_err_r;

endmodule
